pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RV32I core (IF/ID/EX/MEM/WB).
- Consumes decoded control from ID and EX (mem-read, rd, rs1/rs2 usage, branch outcome) plus memory handshakes.
- Drives stall/flush enables for the PC and every pipeline register.
- Adds an FSM for data-memory wait freezes and a debug halt/drain/resume sequence.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               sequencer state encoding and the default register-address
//               width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;

    typedef enum logic [1:0] {
        PH_RUN      = 2'd0,
        PH_MEM_WAIT = 2'd1,
        PH_DRAIN    = 2'd2,
        PH_HALTED   = 2'd3
    } ph_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_load_use_detect
// Description : Combinational load-use comparator. Flags when the load in EX
//               writes a non-zero register that the ID instruction reads.
// Ports       : id_rs1/id_rs2, id_use_rs1/id_use_rs2 - ID source operands
//               ex_mem_read, ex_rd                    - EX load destination
//               hazard                                - load-use hazard bit
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl_load_use_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load "into" x0 never creates a hazard.
    assign hazard    = ex_mem_read && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline sequencer for a 5-stage RV32I core. Produces stall
//               and flush enables for the PC and pipeline registers from
//               load-use hazards, taken branches, fetch/data memory waits and
//               a debug halt/drain/resume sequence.
// Ports       : clk, rst (async, active-high)
//               id_*        - ID operand usage
//               ex_*        - EX load / destination / branch outcome
//               mem_req/mem_ready, imem_ready - memory handshakes
//               halt_req, resume             - debug control
//               pc_stall .. mem_wb_flush     - pipeline control enables
//               halted                       - core drained and stopped
//               perf_stall_cnt, perf_flush_cnt (only with PIPE_HAZARD_PERF_EN)
// Options     : define PIPE_HAZARD_PERF_EN to add saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEFAULT,
    parameter int DRAIN_CYCLES = 4,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic              imem_ready,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              mem_wb_flush,
    output logic              halted
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cnt,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ph_state_t        r_state;
    ph_state_t        w_next_state;
    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_load_use;
    logic             w_mem_wait;
    logic             w_branch_flush;

    pipe_hazard_ctrl_load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (w_load_use)
    );

    assign w_mem_wait = mem_req && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PH_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_drain_cnt;
        w_branch_flush = 1'b0;
        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        mem_wb_flush   = 1'b0;
        halted         = 1'b0;

        case (r_state)
            PH_RUN: begin
                if (w_mem_wait) begin
                    // Full freeze; the data access owns the pipeline.
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                    w_next_state = PH_MEM_WAIT;
                end else begin
                    // A taken branch kills the ID instruction, so any
                    // load-use match against it is irrelevant.
                    if (ex_branch_taken) begin
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        w_branch_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (!imem_ready) begin
                        pc_stall    = 1'b1;
                        if_id_flush = 1'b1;
                    end
                    if (halt_req) begin
                        w_next_state = PH_DRAIN;
                        w_next_cnt   = CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            PH_MEM_WAIT: begin
                // The release cycle drives nothing; a held branch is taken
                // up in the following RUN cycle.
                if (!mem_ready) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end else begin
                    w_next_state = PH_RUN;
                end
            end
            PH_DRAIN: begin
                if (w_mem_wait) begin
                    // Wait inside drain: freeze and hold the counter.
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_flush = 1'b1;
                end else begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    if (ex_branch_taken) begin
                        id_ex_flush    = 1'b1;
                        w_branch_flush = 1'b1;
                    end
                    if (r_drain_cnt == '0) begin
                        w_next_state = PH_HALTED;
                    end else begin
                        w_next_cnt = r_drain_cnt - CNT_W'(1);
                    end
                end
            end
            PH_HALTED: begin
                halted      = 1'b1;
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (resume) begin
                    w_next_state = PH_RUN;
                end
            end
            default: begin
                w_next_state = PH_RUN;
            end
        endcase

        // Outputs are forced quiet for as long as reset is held.
        if (rst) begin
            w_branch_flush = 1'b0;
            pc_stall       = 1'b0;
            if_id_stall    = 1'b0;
            if_id_flush    = 1'b0;
            id_ex_stall    = 1'b0;
            id_ex_flush    = 1'b0;
            ex_mem_stall   = 1'b0;
            mem_wb_flush   = 1'b0;
            halted         = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pc_stall && (r_state != PH_HALTED) && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
            end
            if (w_branch_flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
            end
        end
    end
`else
    logic        w_unused_branch_flush;
    logic [31:0] w_unused_perf_w;
    assign w_unused_branch_flush = w_branch_flush;
    assign w_unused_perf_w       = PERF_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. Directed scenarios
//               followed by randomized traffic, all compared against a
//               behavioural model of the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int REG_AW       = 5;
    localparam int DRAIN_CYCLES = 4;
    localparam int PERF_W       = 32;

    // Expected-output patterns, bit order:
    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //  ex_mem_stall, mem_wb_flush, halted}
    localparam logic [7:0] C_FREEZE  = 8'hD6;
    localparam logic [7:0] C_BRANCH  = 8'h28;
    localparam logic [7:0] C_LOADUSE = 8'hC8;
    localparam logic [7:0] C_NOFETCH = 8'hA0;
    localparam logic [7:0] C_DRAIN_B = 8'hA8;
    localparam logic [7:0] C_HALTED  = 8'hA9;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic              mem_req, mem_ready, imem_ready, halt_req, resume;
    logic              pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic              id_ex_flush, ex_mem_stall, mem_wb_flush, halted;
`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit          m_waiting;
    bit          m_draining;
    bit          m_stopped;
    int          m_drained;
    int unsigned m_stalls;
    int unsigned m_flushes;
    logic [7:0]  obs_last;

    wire [7:0] obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                      id_ex_flush, ex_mem_stall, mem_wb_flush, halted};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW       (REG_AW),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .PERF_W       (PERF_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .imem_ready      (imem_ready),
        .halt_req        (halt_req),
        .resume          (resume),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_stall     (id_ex_stall),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_stall    (ex_mem_stall),
        .mem_wb_flush    (mem_wb_flush),
        .halted          (halted)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 1; imem_ready = 1; halt_req = 0; resume = 0;
    endtask

    task automatic model_reset();
        m_waiting = 0; m_draining = 0; m_stopped = 0; m_drained = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    // One clock cycle: sample at the falling edge, compare, advance the model.
    task automatic tick(input string tag);
        logic [7:0] e;
        bit         wait_now, lu, was_stopped, br_fl;
        @(negedge clk);
        #1;
        e           = 8'h00;
        br_fl       = 0;
        was_stopped = m_stopped;
        wait_now    = mem_req && !mem_ready;
        lu          = ex_mem_read && (ex_rd != 0) &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (rst) begin
            model_reset();
        end else if (m_stopped) begin
            e = C_HALTED;
            if (resume) m_stopped = 0;
        end else if (m_waiting) begin
            if (!mem_ready) e = C_FREEZE;
            else            m_waiting = 0;
        end else if (wait_now) begin
            e = C_FREEZE;
            if (!m_draining) m_waiting = 1;
        end else if (m_draining) begin
            e     = ex_branch_taken ? C_DRAIN_B : C_NOFETCH;
            br_fl = ex_branch_taken;
            m_drained++;
            if (m_drained == DRAIN_CYCLES) begin
                m_draining = 0;
                m_stopped  = 1;
            end
        end else begin
            if (ex_branch_taken) begin
                e     = C_BRANCH;
                br_fl = 1;
            end else if (lu)          e = C_LOADUSE;
            else if (!imem_ready)     e = C_NOFETCH;
            if (halt_req) begin
                m_draining = 1;
                m_drained  = 0;
            end
        end
        obs_last = obs;
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, e);
        end
`ifdef PIPE_HAZARD_PERF_EN
        checks++;
        assert (perf_stall_cnt === PERF_W'(m_stalls)) else begin
            failures++;
            $error("FAIL %s perf_stall_cnt observed=%0d expected=%0d", tag, perf_stall_cnt, m_stalls);
        end
        checks++;
        assert (perf_flush_cnt === PERF_W'(m_flushes)) else begin
            failures++;
            $error("FAIL %s perf_flush_cnt observed=%0d expected=%0d", tag, perf_flush_cnt, m_flushes);
        end
        if (!rst) begin
            if (e[7] && !was_stopped) m_stalls++;
            if (br_fl) m_flushes++;
        end
`else
        if (br_fl || was_stopped) m_flushes = m_flushes;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1;
        idle();
        model_reset();
        tick("reset_hold");
        rst = 0;
        tick("reset_release_idle");

        // Load-use on rs1, then the same with ex_rd = x0
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        tick("load_use_rs1");
        idle();
        tick("load_use_cleared");
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        tick("load_use_x0");
        ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_use_rs1 = 0;
        tick("load_use_rs2");
        id_use_rs2 = 0;
        tick("load_use_unused_operand");

        // Branch over hazard; load-use plus missing fetch
        idle();
        ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; ex_branch_taken = 1;
        tick("branch_over_load_use");
        ex_branch_taken = 0; imem_ready = 0;
        tick("load_use_and_no_fetch");
        idle(); imem_ready = 0;
        tick("no_fetch");

        // Memory wait with a branch held through the freeze
        idle(); mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        tick("mem_wait_entry");
        tick("mem_wait_1");
        tick("mem_wait_2");
        mem_ready = 1;
        tick("mem_wait_release");
        mem_req = 0;
        tick("held_branch_after_release");

        // Halt: drain then halted, then resume
        idle(); halt_req = 1;
        tick("halt_request");
        halt_req = 0; n = 0;
        do begin
            tick("drain");
            n++;
        end while (!obs_last[0] && n < 20);
        checks++;
        assert (n == DRAIN_CYCLES + 1) else begin
            failures++;
            $error("FAIL halt_latency observed=%0d expected=%0d", n, DRAIN_CYCLES + 1);
        end
        tick("halted_hold");
        resume = 1;
        tick("resume_pulse");
        idle();
        tick("after_resume");

        // Drain with a two-cycle memory wait
        halt_req = 1;
        tick("halt_request_2");
        halt_req = 0; n = 0;
        do begin
            mem_req   = (n == 1 || n == 2);
            mem_ready = !(n == 1 || n == 2);
            ex_branch_taken = (n == 3);
            tick("drain_with_wait");
            n++;
        end while (!obs_last[0] && n < 20);
        checks++;
        assert (n == DRAIN_CYCLES + 3) else begin
            failures++;
            $error("FAIL halt_latency_with_wait observed=%0d expected=%0d", n, DRAIN_CYCLES + 3);
        end
        idle(); resume = 1;
        tick("resume_2");
        idle();

        // Asynchronous reset in the middle of a memory wait
        mem_req = 1; mem_ready = 0;
        tick("wait_before_reset");
        tick("wait_before_reset_2");
        rst = 1;
        #1;
        checks++;
        assert (obs === 8'h00) else begin
            failures++;
            $error("FAIL async_reset_outputs observed=%b expected=%b", obs, 8'h00);
        end
        tick("reset_in_wait");
        rst = 0; idle();
        ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        tick("run_after_reset");

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            id_rs1          = REG_AW'($urandom_range(0, 3));
            id_rs2          = REG_AW'($urandom_range(0, 3));
            ex_rd           = REG_AW'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req         = 1'($urandom_range(0, 1));
            mem_ready       = ($urandom_range(0, 3) != 0);
            imem_ready      = ($urandom_range(0, 4) != 0);
            halt_req        = ($urandom_range(0, 15) == 0);
            resume          = ($urandom_range(0, 5) == 0);
            tick("random");
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
